// File: rtl/packet_assembler.sv
// Packs MSB-first flits from a router's local port into packets and buffers
// them in a show-ahead FIFO. Define PACKET_ASSEMBLER_DROP_COUNT_EN to count dropped flits.
module packet_assembler #(
  parameter int FLIT_SIZE   = 4,
  parameter int PACKET_SIZE = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLIT_SIZE-1:0]   flit_in,
  input  logic                   write_req,
  output logic                   full,
  output logic [PACKET_SIZE-1:0] packet_out,
  output logic                   packet_valid,
  input  logic                   packet_read,
  output logic [7:0]             drop_count
);

  localparam int FLITS   = PACKET_SIZE / FLIT_SIZE;
  localparam int CNT_W   = $clog2(FLITS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]   LAST_FLIT = CNT_W'(FLITS - 1);
  localparam logic [COUNT_W-1:0] DEPTH_C   = COUNT_W'(FIFO_DEPTH);

  // Handshakes: a flit transfers on write_req && !full; a packet transfers on
  // packet_read && packet_valid. full and packet_valid are pure register decodes.

  logic [CNT_W-1:0]       flit_cnt;
  logic [PACKET_SIZE-1:0] asm_reg;
  logic [PACKET_SIZE-1:0] packet_word;
  logic [PACKET_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [COUNT_W-1:0]     count;
  logic                   accept;
  logic                   push;
  logic                   pop;

  assign full         = (count == DEPTH_C);
  assign packet_valid = (count != '0);
  assign packet_out   = packet_valid ? mem[rd_ptr] : '0;

  always_comb begin
    accept      = write_req && !full;
    push        = accept && (flit_cnt == LAST_FLIT);
    pop         = packet_read && packet_valid;
    packet_word = (asm_reg << FLIT_SIZE) | PACKET_SIZE'(flit_in);
  end

  // The assembly register is cleared once a packet leaves it so it never
  // carries stale flits into the next packet.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flit_cnt <= '0;
      asm_reg  <= '0;
    end else if (accept) begin
      flit_cnt <= flit_cnt + 1'b1;
      asm_reg  <= push ? '0 : packet_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= packet_word;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PACKET_ASSEMBLER_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (write_req && full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: vector table, directed corner sequences and
// random traffic against a queue-based packet model.
module tb_packet_assembler;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  flit_in;
  logic        write_req;
  logic        full;
  logic [31:0] packet_out;
  logic        packet_valid;
  logic        packet_read;
  logic [7:0]  drop_count;

  int tests;
  int fails;

  logic [31:0] exp_q[$];
  logic [3:0]  part_q[$];
  int          drops_m;

  typedef struct {
    logic        wr;
    logic [3:0]  flit;
    logic        rd;
    logic        exp_valid;
    logic        exp_full;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[9];

  packet_assembler #(.FLIT_SIZE(4), .PACKET_SIZE(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flit_in      (flit_in),
    .write_req    (write_req),
    .full         (full),
    .packet_out   (packet_out),
    .packet_valid (packet_valid),
    .packet_read  (packet_read),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: flits collect into a partial packet; eight of them make one word.
  task automatic model_step(input logic wr, input logic [3:0] flit, input logic rd);
    logic        full_m;
    logic [31:0] word;
    full_m = (exp_q.size() == DEPTH);
    if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
    if (wr) begin
      if (full_m) begin
        if (drops_m < 255) drops_m++;
      end else begin
        part_q.push_back(flit);
        if (part_q.size() == 8) begin
          word = 32'h0;
          foreach (part_q[i]) word = (word << 4) | {28'h0, part_q[i]};
          exp_q.push_back(word);
          part_q.delete();
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_drops();
`ifdef PACKET_ASSEMBLER_DROP_COUNT_EN
    return drops_m[7:0];
`else
    return 8'd0;
`endif
  endfunction

  task automatic drive(input logic wr, input logic [3:0] flit, input logic rd);
    write_req   = wr;
    flit_in     = flit;
    packet_read = rd;
    model_step(wr, flit, rd);
    @(posedge clk);
    #1;
    write_req   = 1'b0;
    packet_read = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, {31'h0, packet_valid}, {31'h0, exp_q.size() != 0});
    check({tag, ".full"}, {31'h0, full}, {31'h0, exp_q.size() == DEPTH});
    check({tag, ".out"}, packet_out, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    check({tag, ".drop"}, {24'h0, drop_count}, {24'h0, exp_drops()});
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    write_req   = 1'b0;
    packet_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    part_q.delete();
    drops_m = 0;
  endtask

  task automatic send_word(input logic [31:0] word, input logic rd_on_last);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, word[(7-i)*4 +: 4], rd_on_last && (i == 7));
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    drops_m     = 0;
    reset       = 1'b0;
    write_req   = 1'b0;
    packet_read = 1'b0;
    flit_in     = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();
    check("reset.full", {31'h0, full}, 32'h0);
    check("reset.valid", {31'h0, packet_valid}, 32'h0);
    check("reset.out", packet_out, 32'h0);
    check("reset.drop", {24'h0, drop_count}, 32'h0);

    // Flits 1..8 assemble into 12345678, visible the cycle after the 8th flit.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{wr: 1'b1, flit: 4'(i + 1), rd: 1'b0, exp_valid: (i == 7),
                  exp_full: 1'b0, exp_out: (i == 7) ? 32'h12345678 : 32'h0};
    end
    vecs[8] = '{wr: 1'b0, flit: 4'h0, rd: 1'b0, exp_valid: 1'b1,
                exp_full: 1'b0, exp_out: 32'h12345678};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].wr, vecs[i].flit, vecs[i].rd);
      check($sformatf("vec%0d.valid", i), {31'h0, packet_valid}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d.full", i), {31'h0, full}, {31'h0, vecs[i].exp_full});
      check($sformatf("vec%0d.out", i), packet_out, vecs[i].exp_out);
    end

    // Fill to full, then a 9-flit burst is dropped without disturbing the FIFO.
    do_reset();
    for (int p = 1; p <= 4; p++) send_word(32'hA0000000 + 32'(p), 1'b0);
    check("fill.full", {31'h0, full}, 32'h1);
    for (int i = 0; i < 9; i++) drive(1'b1, 4'(i), 1'b0);
`ifdef PACKET_ASSEMBLER_DROP_COUNT_EN
    check("burst.drop", {24'h0, drop_count}, 32'd9);
`else
    check("burst.drop", {24'h0, drop_count}, 32'd0);
`endif
    check_model("burst");
    for (int p = 1; p <= 4; p++) begin
      check($sformatf("burst.pop%0d", p), packet_out, 32'hA0000000 + 32'(p));
      drive(1'b0, 4'h0, 1'b1);
    end
    check("burst.empty", {31'h0, packet_valid}, 32'h0);

    // Push and pop in the same cycle with three packets queued.
    do_reset();
    for (int p = 1; p <= 3; p++) send_word(32'hB0000000 + 32'(p), 1'b0);
    send_word(32'hDEADBEEF, 1'b1);
    check("pushpop.full", {31'h0, full}, 32'h0);
    check_model("pushpop");
    check("pushpop.head", packet_out, 32'hB0000002);
    drive(1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1);
    check("pushpop.last", packet_out, 32'hDEADBEEF);
    drive(1'b0, 4'h0, 1'b1);
    check("pushpop.empty", {31'h0, packet_valid}, 32'h0);

    // Reset mid-packet discards the partial flits.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'h3, 1'b0);
    do_reset();
    send_word(32'hFEDCBA98, 1'b0);
    check("midreset.out", packet_out, 32'hFEDCBA98);
    drive(1'b0, 4'h0, 1'b1);
    check("midreset.single", {31'h0, packet_valid}, 32'h0);

    // Reads while empty are ignored.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, 4'h0, 1'b1);
    send_word(32'h0000000F, 1'b0);
    check("spurious.valid", {31'h0, packet_valid}, 32'h1);
    check("spurious.out", packet_out, 32'h0000000F);
    check("spurious.full", {31'h0, full}, 32'h0);
    drive(1'b0, 4'h0, 1'b1);
    check("spurious.count1", {31'h0, packet_valid}, 32'h0);

    // Drop counter saturation.
    do_reset();
    for (int p = 0; p < 4; p++) send_word($urandom, 1'b0);
    for (int i = 0; i < 300; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1'b0);
`ifdef PACKET_ASSEMBLER_DROP_COUNT_EN
    check("sat.drop", {24'h0, drop_count}, 32'd255);
`else
    check("sat.drop", {24'h0, drop_count}, 32'd0);
`endif
    check_model("sat");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 2);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
